max_pool_2x2: RTL and testbench

MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

---
 rtl/max_pool_2x2.sv | 148 ++++++++++++++
 tb/tb_max_pool_2x2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over raster-order IN_DIM x IN_DIM frames.
// Optional build macro MAX_POOL_RELU_EN clamps negative pooled results to 0.
module max_pool_2x2 #(
    parameter int DATA_W = 36,
    parameter int IN_DIM = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int CW   = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
    localparam int HALF = IN_DIM / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVEN = 2'd1;
    localparam logic [1:0] ODD  = 2'd2;

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic [CW-1:0]             row;
    logic [CW-1:0]             col;
    logic signed [DATA_W-1:0]  pair;
    logic signed [DATA_W-1:0]  linebuf [HALF];

    logic                      accept;
    logic                      col_end;
    logic                      row_end;
    logic                      odd_row;
    logic                      odd_col;
    logic                      complete;
    logic                      lb_write;
    logic [HW-1:0]             half_idx;
    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W-1:0]  even_max;
    logic signed [DATA_W-1:0]  top_max;
    logic signed [DATA_W-1:0]  quad_max;
    logic signed [DATA_W-1:0]  result;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign accept   = in_valid & ~clr;
    assign col_end  = (col == LAST);
    assign row_end  = (row == LAST);
    assign odd_row  = (state == ODD);
    assign odd_col  = col[0];
    assign complete = accept & odd_row & odd_col;
    assign lb_write = accept & ~odd_row & odd_col;
    assign half_idx = HW'(col >> 1);
    assign sample   = $signed(in_data);

    assign even_max = smax(pair, sample);
    assign top_max  = smax(linebuf[half_idx], pair);
    assign quad_max = smax(top_max, sample);

    always_comb begin
        result = quad_max;
`ifdef MAX_POOL_RELU_EN
        if (quad_max[DATA_W-1]) begin
            result = '0;
        end
`endif
    end

    // Row parity lives in the state; the last row is always odd.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (accept) begin
            unique case (state)
                IDLE: state_nxt = EVEN;
                EVEN: state_nxt = col_end ? ODD : EVEN;
                ODD: begin
                    if (col_end) begin
                        state_nxt = row_end ? IDLE : EVEN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair <= '0;
            for (int i = 0; i < HALF; i++) begin
                linebuf[i] <= '0;
            end
        end else begin
            if (accept && !odd_col) begin
                pair <= sample;
            end
            if (lb_write) begin
                linebuf[half_idx] <= even_max;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= complete;
            out_last  <= complete & row_end & col_end;
            if (complete) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: whole-frame reference model, directed and random frames.
// Honours MAX_POOL_RELU_EN the same way the design does.
module tb_max_pool_2x2;

    localparam int DW = 36;
    localparam int D  = 12;
    localparam int N  = D * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;

    max_pool_2x2 #(.DATA_W(DW), .IN_DIM(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clr      (clr),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int                   n_vec = 0;
    int                   n_err = 0;
    logic signed [DW-1:0] fm [N];
    int                   pos = 0;
    logic                 exp_v = 1'b0;
    logic                 exp_l = 1'b0;
    logic [DW-1:0]        exp_d = '0;
    int                   n_out = 0;
    logic [DW-1:0]        oq [$];
    logic [DW-1:0]        m5;
    logic [DW-1:0]        neg_exp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] mx(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Reference: keep the whole frame, pool the 2x2 window when its last pixel lands.
    task automatic model(input logic v, input logic [DW-1:0] d, input logic c);
        int r;
        int k;
        logic signed [DW-1:0] m;
        exp_v = 1'b0;
        exp_l = 1'b0;
        if (c) begin
            pos = 0;
        end else if (v) begin
            fm[pos] = $signed(d);
            r = pos / D;
            k = pos % D;
            if ((r % 2 == 1) && (k % 2 == 1)) begin
                m = mx(mx(fm[(r-1)*D+k-1], fm[(r-1)*D+k]),
                       mx(fm[r*D+k-1], fm[r*D+k]));
`ifdef MAX_POOL_RELU_EN
                if (m < 0) m = '0;
`endif
                exp_v = 1'b1;
                exp_d = m;
                exp_l = (pos == N - 1);
            end
            pos = (pos + 1) % N;
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        model(v, d, c);
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        chk("out_last", {63'd0, out_last}, {63'd0, exp_l});
        if (exp_v) begin
            chk("out_data", {28'd0, out_data}, {28'd0, exp_d});
        end
        if (out_valid) begin
            n_out++;
            oq.push_back(out_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic ramp(input logic toggle);
        for (int i = 0; i < N; i++) begin
            step(1'b1, DW'(i), 1'b0);
            if (toggle) step(1'b0, '0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_data", {28'd0, out_data}, 64'd0);
        pos   = 0;
        exp_v = 1'b0;
        exp_l = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_test();
        n_out = 0;
        oq.delete();
    endtask

    task automatic ramp_ends(input string tag, input int base);
        if (oq.size() >= base + 36) begin
            chk({tag, "_first"}, {28'd0, oq[base]}, 64'd13);
            chk({tag, "_sixth"}, {28'd0, oq[base+5]}, 64'd23);
            chk({tag, "_seventh"}, {28'd0, oq[base+6]}, 64'd37);
            chk({tag, "_final"}, {28'd0, oq[base+35]}, 64'd143);
        end else begin
            chk({tag, "_size"}, 64'(oq.size()), 64'(base + 36));
        end
    endtask

    initial begin
        m5 = DW'(-5);
`ifdef MAX_POOL_RELU_EN
        neg_exp = '0;
`else
        neg_exp = m5;
`endif
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_data", {28'd0, out_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_test();
        ramp(1'b0);
        idle(3);
        chk("ramp_cnt", 64'(n_out), 64'd36);
        ramp_ends("ramp", 0);

        start_test();
        ramp(1'b1);
        idle(3);
        chk("toggle_cnt", 64'(n_out), 64'd36);
        ramp_ends("toggle", 0);

        start_test();
        for (int i = 0; i < N; i++) step(1'b1, m5, 1'b0);
        idle(3);
        chk("neg_cnt", 64'(n_out), 64'd36);
        if (oq.size() > 0) begin
            chk("neg_val", {28'd0, oq[0]}, {28'd0, neg_exp});
        end

        start_test();
        for (int i = 0; i < 50; i++) step(1'b1, DW'(i), 1'b0);
        do_reset();
        n_out = 0;
        oq.delete();
        ramp(1'b0);
        idle(3);
        chk("rstmid_cnt", 64'(n_out), 64'd36);
        ramp_ends("rstmid", 0);

        start_test();
        ramp(1'b0);
        ramp(1'b0);
        idle(3);
        chk("b2b_cnt", 64'(n_out), 64'd72);
        ramp_ends("b2b1", 0);
        ramp_ends("b2b2", 36);

        start_test();
        for (int i = 0; i < 30; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, DW'(30), 1'b1);
        idle(2);
        chk("clr_pre_cnt", 64'(n_out), 64'd6);
        ramp(1'b0);
        idle(3);
        chk("clr_cnt", 64'(n_out), 64'd42);
        ramp_ends("clr", 6);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                logic [DW-1:0] d;
                d = (f % 2 == 0) ? DW'({$urandom, $urandom})
                                 : DW'($signed($urandom_range(0, 6)) - 3);
                idle($urandom_range(0, 2));
                step(1'b1, d, ($urandom_range(0, 299) == 0));
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
